id_queue_stage: RTL and testbench
=================================

# id_queue_stage

Parametrised successor to the decode-stage input latch: a DEPTH-entry instruction queue in front of the decoder, plus the registered instruction/PC output that the decoder and the ID/EX logic consume. Fetch pushes {instr, pc} pairs with a valid/ready handshake. The block forwards one pair per cycle to its output register, which holds under `stall`. A `flush` from branch/jump resolution kills both the queue and the output register, so a bubble (NOP) enters decode.

## Interface
Parameters:
- `DATA_W`, 32, instruction width.
- `ADDR_W`, 32, PC width.
- `DEPTH`, 4, queue entries; power of two, ≥ 2.
- `NOP_INSTR`, 32'h0000_0000, value driven on `out_instr` for a bubble (DATA_W bits).

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  fetch presents a pair.
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `in_instr`  in  DATA_W  fetched instruction.
- `in_pc`  in  ADDR_W  PC of `in_instr`.
- `stall`  in  1  hazard unit: output register holds, no dequeue.
- `flush`  in  1  discard queue and output register.
- `out_valid`  out  1  output register holds a real instruction.
- `out_instr`  out  DATA_W  instruction to decoder; `NOP_INSTR` when `out_valid`=0.
- `out_pc`  out  ADDR_W  PC of `out_instr`; 0 when `out_valid`=0.
- `count`  out  $clog2(DEPTH)+1  queue occupancy, excluding the output register.

## Operation
- Storage is a circular buffer with read pointer, write pointer and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push: `push = in_valid & in_ready & !flush`. The pair is written at the write pointer, which then increments.
- Source: `src` is the queue head if `count > 0`, else the input pair if `push` (write-through), else none.
- Load: output register loads when `!stall & !flush`.
  - If `src` exists: load it with `out_valid`=1, and pop the queue if `src` is the head.
  - If `src` is none: load a bubble (`out_valid`=0, `NOP_INSTR`, pc 0).
- Write-through with `count`=0: the pair goes straight to the output register and is not stored, so `count` stays 0.
- Stall: output register and all three outputs hold unchanged. Pushes continue until full.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full: `in_ready`=0, and the offered pair is not accepted; fetch must hold it. A pop in that same cycle does not make the current cycle accept. `in_ready` rises the following cycle.
- Flush has priority over push, pop and stall. In one cycle it:
  - sets both pointers and `count` to 0;
  - loads a bubble into the output register;
  - drops any pair offered that cycle, even if `in_ready`=1. Fetch must re-fetch from the redirected PC.
- Reset has priority over flush and gives the same end state.
- Reset values: `out_valid`=0, `out_instr`=`NOP_INSTR`, `out_pc`=0, `count`=0, `in_ready`=1, pointers 0. Queue RAM contents are don't-care.

## Timing
- All state updates on the rising edge of `clk`. `in_ready` and `count` are combinational from registered state only; there is no combinational path from any input to any output.
- Latency, empty queue, no stall: pair accepted at edge N appears on `out_*` after edge N.
- Latency with backlog: one output per non-stalled cycle, in FIFO order.
- Sustained throughput is 1 pair/cycle with `stall`=0. Occupancy stays 0 under continuous push/pop.
- `flush` asserted at edge N gives, after edge N, `out_valid`=0, `count`=0, `in_ready`=1. A push at edge N+1 is accepted normally.
- Reset mid-operation behaves identically to flush, plus all outputs return to their reset values.

## Test plan
- Reset, then stream 8 pairs (pc 0x00,0x04,…,0x1C) with `stall`=0 -> each appears on `out_*` one cycle after acceptance; `count` stays 0; `in_ready` stays 1.
- `stall`=1 for 6 cycles while pushing pc 0x100.. (DEPTH=4) -> `count` climbs 1..4, and `in_ready`=0 at 4. The 5th pair is held by fetch, not lost. Output holds its pre-stall pc. After releasing stall, pcs 0x100,0x104,0x108,0x10C,0x110 emerge in order, one per cycle.
- Full queue, release stall with `in_valid`=1 -> in the release cycle one pop and no push; `count` goes 4→3. Next cycle push and pop occur together and `count` stays 3.
- `flush`=1 with `count`=3, `stall`=1 and `in_valid`=1 (pc 0x200) -> next cycle `out_valid`=0, `out_instr`=`NOP_INSTR`, `count`=0. Pc 0x200 never appears.
- Pointer wrap: push/pop 3·DEPTH+1 pairs with an alternating stall pattern -> output order and pc values match a reference FIFO model exactly.
- Assert `reset` mid-stream with `count`=2 -> next cycle all outputs are at their reset values, and a subsequent push emerges one cycle later.

Source files
------------

// File: rtl/id_queue_stage.sv
// Decode-stage instruction queue: DEPTH-entry FIFO of {instr, pc} pairs
// feeding a registered output that holds under stall and bubbles on flush.
module id_queue_stage #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] occ;

    logic push;
    logic load;
    logic has_head;
    logic pop;
    logic thru;
    logic store;

    assign count    = occ;
    assign in_ready = (occ != FULL);

    always_comb begin
        push     = in_valid & in_ready & ~flush;
        load     = ~stall & ~flush;
        has_head = (occ != '0);
        pop      = load & has_head;
        // An empty queue hands the incoming pair straight to the output.
        thru     = load & ~has_head & push;
        store    = push & ~thru;
    end

    always_ff @(posedge clk) begin
        if (store) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({store, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
            if (load) begin
                if (has_head) begin
                    out_valid <= 1'b1;
                    out_instr <= instr_mem[rd_ptr];
                    out_pc    <= pc_mem[rd_ptr];
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_instr <= in_instr;
                    out_pc    <= in_pc;
                end else begin
                    out_valid <= 1'b0;
                    out_instr <= NOP_INSTR;
                    out_pc    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_queue_stage.sv
// Scoreboard bench for id_queue_stage: driver queues expected pcs,
// a negedge monitor checks every newly loaded output against them.
module tb_id_queue_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int total = 0;
    int passed = 0;
    logic [31:0] exp_q[$];
    logic load_seen = 1'b0;

    always #5 clk = ~clk;

    id_queue_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'h0013, pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    always @(posedge clk) load_seen <= !stall && !flush && !reset;

    // A new output exists only after an edge that loaded the register.
    always @(negedge clk) begin
        if (load_seen && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL mon_unexpected: got pc %h want none", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("mon_pc", out_pc, e);
                chk("mon_instr", out_instr, instr_of(e));
            end
        end
    end

    task automatic tick(input logic v, input logic [31:0] pc,
                        input logic st, input logic fl, input logic rs,
                        output logic acc);
        @(negedge clk);
        #1;
        in_valid = v;
        in_pc    = pc;
        in_instr = instr_of(pc);
        stall    = st;
        flush    = fl;
        reset    = rs;
        acc = v && in_ready && !fl && !rs;
        if (fl || rs) exp_q.delete();
        if (acc) exp_q.push_back(pc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        logic [31:0] pc;
        int n;
        int cyc;
        int exp_cnt [6] = '{1, 2, 3, 4, 4, 4};

        tick(0, 0, 0, 0, 1, a);
        tick(0, 0, 0, 0, 1, a);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, NOP);
        chk("rst_pc", out_pc, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            tick(1, 32'(i * 4), 0, 0, 0, a);
            chk("str_acc", a, 1);
            chk("str_pc", out_pc, 32'(i * 4));
            chk("str_count", count, 0);
        end

        pc = 32'h100;
        for (int k = 0; k < 6; k++) begin
            tick(1, pc, 1, 0, 0, a);
            if (a) pc += 4;
            chk("stl_count", count, exp_cnt[k]);
            chk("stl_hold", out_pc, 32'h1C);
        end
        chk("stl_ready", in_ready, 0);
        chk("stl_pc_held", pc, 32'h110);

        tick(1, pc, 0, 0, 0, a);
        chk("rel_noacc", a, 0);
        chk("rel_count", count, 3);
        chk("rel_pc", out_pc, 32'h100);
        tick(1, pc, 0, 0, 0, a);
        chk("rel2_acc", a, 1);
        chk("rel2_count", count, 3);
        chk("rel2_pc", out_pc, 32'h104);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0, 0, a);
            chk("drn_pc", out_pc, 32'(32'h108 + k * 4));
            chk("drn_count", count, 32'(2 - k));
        end

        for (int k = 0; k < 3; k++) tick(1, 32'(32'h180 + k * 4), 1, 0, 0, a);
        chk("pre_fl_count", count, 3);
        tick(1, 32'h200, 1, 1, 0, a);
        chk("fl_valid", out_valid, 0);
        chk("fl_instr", out_instr, NOP);
        chk("fl_pc", out_pc, 0);
        chk("fl_count", count, 0);
        chk("fl_ready", in_ready, 1);
        tick(1, 32'h300, 0, 0, 0, a);
        chk("postfl_valid", out_valid, 1);
        chk("postfl_pc", out_pc, 32'h300);
        chk("postfl_count", count, 0);

        n = 0;
        cyc = 0;
        while (n < 13 && cyc < 200) begin
            tick(1, 32'(32'h400 + n * 4), cyc[0], 0, 0, a);
            if (a) n++;
            cyc++;
        end
        chk("wrap_acc", 32'(n), 13);
        cyc = 0;
        while (count != 0 && cyc < 50) begin
            tick(0, 0, 0, 0, 0, a);
            cyc++;
        end
        tick(0, 0, 0, 0, 0, a);
        chk("wrap_drained", 32'(exp_q.size()), 0);
        chk("wrap_bubble", out_valid, 0);

        tick(1, 32'h500, 1, 0, 0, a);
        tick(1, 32'h504, 1, 0, 0, a);
        chk("mid_count", count, 2);
        tick(0, 0, 0, 0, 1, a);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_instr", out_instr, NOP);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ready", in_ready, 1);
        tick(1, 32'h600, 0, 0, 0, a);
        chk("mrst_push_valid", out_valid, 1);
        chk("mrst_push_pc", out_pc, 32'h600);
        chk("mrst_push_count", count, 0);

        tick(0, 0, 0, 0, 0, a);
        tick(0, 0, 0, 0, 0, a);
        chk("end_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
